// File: rtl/pipeline_stage_pkg.sv
// Shared types for the elastic pipeline stage register.
// The skid FSM encoding is only used when SKID_BUFFER_EN is defined.
package pipeline_stage_pkg;

  typedef enum logic [1:0] {
    Empty = 2'd0,
    Busy  = 2'd1,
    Full  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipeline_skid_slot.sv
// Single hold register for the second entry of the skid buffer.
// Only compiled when SKID_BUFFER_EN is defined; the default build has no skid slot.
`ifdef SKID_BUFFER_EN
module pipeline_skid_slot #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    BUBBLE     = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Hold register: clear wins over load so a flush never keeps a payload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= BUBBLE;
    end else if (clear) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`endif

// File: rtl/pipeline_stage_register.sv
// Elastic valid/ready register between two dataflow stages, with flush to BUBBLE.
// Build option SKID_BUFFER_EN: 2-entry skid buffer with registered in_ready.
// Without it: 1-entry register with combinational in_ready.
module pipeline_stage_register
  import pipeline_stage_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BUBBLE     = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef SKID_BUFFER_EN

  skid_state_t           state_q;
  skid_state_t           state_d;
  logic                  out_load;
  logic                  out_from_skid;
  logic                  skid_load;
  logic [DATA_WIDTH-1:0] skid_q;

  pipeline_skid_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUBBLE     (BUBBLE)
  ) u_skid_slot (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (flush),
    .d     (in_data),
    .q     (skid_q)
  );

  // Next-state and datapath steering; the skid slot only fills while the output is stalled.
  always_comb begin
    state_d       = state_q;
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    if (flush) begin
      state_d = Empty;
    end else begin
      unique case (state_q)
        Empty: begin
          if (in_xfer) begin
            state_d  = Busy;
            out_load = 1'b1;
          end
        end
        Busy: begin
          unique case ({in_xfer, out_xfer})
            2'b11: out_load = 1'b1;
            2'b10: begin
              state_d   = Full;
              skid_load = 1'b1;
            end
            2'b01: state_d = Empty;
            default: state_d = Busy;
          endcase
        end
        Full: begin
          if (out_xfer) begin
            state_d       = Busy;
            out_load      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_d = Empty;
      endcase
    end
  end

  // State, output register and registered handshake flags derived from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= Empty;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= BUBBLE;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d != Empty);
      in_ready  <= (state_d != Full);
      if (flush) begin
        out_data <= BUBBLE;
      end else if (out_load) begin
        out_data <= out_from_skid ? skid_q : in_data;
      end
    end
  end

`else

  // Accept whenever the output slot is empty or being drained this cycle.
  always_comb begin
    in_ready = !out_valid || out_ready;
  end

  // Single output register; flush beats a same-cycle input transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed and random scoreboard bench for pipeline_stage_register (works with or without SKID_BUFFER_EN).
module tb_pipeline_stage_register;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_q[$];
  logic        bubble_state;

  pipeline_stage_register #(
    .DATA_WIDTH (32),
    .BUBBLE     (32'h0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_in_ready(input logic orr);
`ifdef SKID_BUFFER_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || orr;
`endif
  endfunction

  // Drive one cycle at the negedge, check outputs against the model, then update the model.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic orr, input logic fl);
    logic eir;
    logic eov;
    @(negedge clock);
    in_valid  = iv;
    in_data   = id;
    out_ready = orr;
    flush     = fl;
    #1;
    eir = exp_in_ready(orr);
    eov = (exp_q.size() != 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, eov});
    chk("in_ready", {31'd0, in_ready}, {31'd0, eir});
    if (eov) chk("out_data", out_data, exp_q[0]);
    else if (bubble_state) chk("bubble", out_data, 32'h0);
    if (eov && orr) void'(exp_q.pop_front());
    if (fl) begin
      exp_q.delete();
      bubble_state = 1'b1;
    end else if (iv && eir) begin
      exp_q.push_back(id);
      bubble_state = 1'b0;
    end
  endtask

  initial begin
    // 1: reset with junk on the input
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    exp_q.delete();
    bubble_state = 1'b1;
    @(posedge clock); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;

    // 2: stream 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) cycle(1'b1, i, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // 3: stall with A held, then offer B under stall, then release
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
`ifdef SKID_BUFFER_EN
    chk("skid_b_taken", exp_q.size(), 32'd2);
`endif
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(exp_q.size() < 2 && exp_q[$] != 32'hB, 32'hB, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // 4: flush beats a same-cycle input while 0x44 is held
    cycle(1'b1, 32'h44, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // 6: reset asserted while holding the maximum number of entries
    cycle(1'b1, 32'h61, 1'b0, 1'b0);
    cycle(1'b1, 32'h62, 1'b0, 1'b0);
    cycle(1'b1, 32'h63, 1'b0, 1'b0);
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_data", out_data, 32'h0);
    exp_q.delete();
    bubble_state = 1'b1;
    @(posedge clock); #1;
    chk("edge_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("edge_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h70 + i, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // 5: random valid/ready/flush against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
